// File: rtl/loop_nest_pkg.sv
// Shared state encoding and default widths for the two-level loop sequencer.
// Pure declarations; no latency or flow control of its own.
package loop_nest_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        CLEAR = 2'd3
    } state_t;

    localparam int OUT_W_DEF = 8;
    localparam int IN_W_DEF  = 8;
    localparam int ACT_N_DEF = 2;
    localparam int ACT_W_DEF = 8;
endpackage

// File: rtl/loop_nest_seq_act_bank.sv
// ACT_N wrapping action counters; clear wins over increment, update lands next edge.
// No backpressure: the owner gates i_inc (stall/abort) before it reaches the bank.
module act_bank #(
    parameter int ACT_N = 2,
    parameter int ACT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_clr,
    input  logic                   i_inc,
    input  logic [ACT_N-1:0]       i_en,
    output logic [ACT_N*ACT_W-1:0] o_cnt
);
    genvar k;
    generate
        for (k = 0; k < ACT_N; k++) begin : g_ch
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    o_cnt[k*ACT_W +: ACT_W] <= '0;
                end else if (i_clr) begin
                    o_cnt[k*ACT_W +: ACT_W] <= '0;
                end else if (i_inc && i_en[k]) begin
                    o_cnt[k*ACT_W +: ACT_W] <= o_cnt[k*ACT_W +: ACT_W] + ACT_W'(1);
                end
            end
        end
    endgenerate
endmodule

// File: rtl/loop_nest_seq.sv
// Two-level loop sequencer: one body per RUN cycle, first step one cycle after start.
// stall freezes indices/counters while running; abort returns to IDLE without done.
module loop_nest_seq
    import loop_nest_pkg::*;
#(
    parameter int OUT_W    = OUT_W_DEF,
    parameter int IN_W     = IN_W_DEF,
    parameter int ACT_N    = ACT_N_DEF,
    parameter int ACT_W    = ACT_W_DEF,
    parameter bit CLR_DONE = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   stall,
    input  logic [OUT_W-1:0]       outer_last,
    input  logic [IN_W-1:0]        inner_last,
    input  logic [ACT_N-1:0]       act_en,
    output logic                   busy,
    output logic                   step,
    output logic [OUT_W-1:0]       x,
    output logic [IN_W-1:0]        y,
    output logic [ACT_N*ACT_W-1:0] act,
    output logic                   done
);
    state_t           r_state;
    logic [OUT_W-1:0] r_ol;
    logic [IN_W-1:0]  r_il;
    logic [ACT_N-1:0] r_en;
    logic             r_busy;
    logic             r_step;
    logic             r_done;
    logic [OUT_W-1:0] r_x;
    logic [IN_W-1:0]  r_y;

    logic w_body;
    logic w_last;
    logic w_clr;

    assign w_body = (r_state == RUN) && !abort && !stall;
    assign w_last = (r_x == r_ol) && (r_y == r_il);
    assign w_clr  = ((r_state == IDLE) && start) || (r_state == CLEAR);

    act_bank #(
        .ACT_N (ACT_N),
        .ACT_W (ACT_W)
    ) u_act_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_clr),
        .i_inc (w_body),
        .i_en  (r_en),
        .o_cnt (act)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ol    <= '0;
            r_il    <= '0;
            r_en    <= '0;
            r_busy  <= 1'b0;
            r_step  <= 1'b0;
            r_done  <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_step <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_ol    <= outer_last;
                        r_il    <= inner_last;
                        r_en    <= act_en;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        r_x     <= '0;
                        r_y     <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (!stall) begin
                        r_step <= 1'b1;
                        // Indices park on the final body so x/y read back the last pair.
                        if (w_last) begin
                            r_state <= DONE;
                        end else if (r_y == r_il) begin
                            r_y <= '0;
                            r_x <= r_x + OUT_W'(1);
                        end else begin
                            r_y <= r_y + IN_W'(1);
                        end
                    end
                end
                DONE: begin
                    r_busy <= 1'b0;
                    if (abort) begin
                        r_x     <= '0;
                        r_y     <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= CLR_DONE ? CLEAR : IDLE;
                    end
                end
                CLEAR: begin
                    r_x     <= '0;
                    r_y     <= '0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign step = r_step;
    assign done = r_done;
    assign x    = r_x;
    assign y    = r_y;
endmodule

// File: tb/tb_loop_nest_seq.sv
// Randomised and directed bench for loop_nest_seq; two instances (clear-after-done
// with 8-bit counters, hold-after-done with 4-bit counters) share one stimulus.
module tb_loop_nest_seq;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start = 1'b0, abort = 1'b0, stall = 1'b0;
    logic [7:0] outer_last = '0, inner_last = '0;
    logic [1:0] act_en = '0;

    logic        busy_a, step_a, done_a, busy_b, step_b, done_b;
    logic [7:0]  x_a, y_a, x_b, y_b;
    logic [15:0] act_a;
    logic [7:0]  act_b;

    loop_nest_seq #(.OUT_W(8), .IN_W(8), .ACT_N(2), .ACT_W(8), .CLR_DONE(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stall(stall),
        .outer_last(outer_last), .inner_last(inner_last), .act_en(act_en),
        .busy(busy_a), .step(step_a), .x(x_a), .y(y_a), .act(act_a), .done(done_a));

    loop_nest_seq #(.OUT_W(8), .IN_W(8), .ACT_N(2), .ACT_W(4), .CLR_DONE(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stall(stall),
        .outer_last(outer_last), .inner_last(inner_last), .act_en(act_en),
        .busy(busy_b), .step(step_b), .x(x_b), .y(y_b), .act(act_b), .done(done_b));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Reference model: progress is a count of executed bodies; indices derive from it.
    // Phase: 0 idle, 1 running, 2 final body done, 3 post-done clear.
    int  m_ph[2]  = '{0, 0};
    int  m_bod[2] = '{0, 0};
    int  m_ol[2]  = '{0, 0};
    int  m_il[2]  = '{0, 0};
    int  m_en[2]  = '{0, 0};
    bit  m_zero[2] = '{1, 1};
    bit  e_busy[2] = '{0, 0};
    bit  e_step[2] = '{0, 0};
    bit  e_done[2] = '{0, 0};
    int  m_act[2][2] = '{'{0, 0}, '{0, 0}};
    int  wmask[2] = '{255, 15};
    bit  clrd[2]  = '{1, 0};

    function automatic int total(input int i);
        return (m_ol[i] + 1) * (m_il[i] + 1);
    endfunction
    function automatic int ex_x(input int i);
        if (m_zero[i]) return 0;
        if (m_bod[i] == total(i)) return m_ol[i];
        return m_bod[i] / (m_il[i] + 1);
    endfunction
    function automatic int ex_y(input int i);
        if (m_zero[i]) return 0;
        if (m_bod[i] == total(i)) return m_il[i];
        return m_bod[i] % (m_il[i] + 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_ph[i] = 0; m_bod[i] = 0; m_ol[i] = 0; m_il[i] = 0; m_en[i] = 0;
                m_zero[i] = 1; e_busy[i] = 0; e_step[i] = 0; e_done[i] = 0;
                m_act[i][0] = 0; m_act[i][1] = 0;
            end else begin
                e_step[i] = 0;
                e_done[i] = 0;
                case (m_ph[i])
                    0: if (start) begin
                        m_ol[i] = outer_last; m_il[i] = inner_last; m_en[i] = act_en;
                        m_bod[i] = 0; m_zero[i] = 0; m_act[i][0] = 0; m_act[i][1] = 0;
                        e_busy[i] = 1; m_ph[i] = 1;
                    end
                    1: if (abort) begin
                        m_ph[i] = 0; m_zero[i] = 1; e_busy[i] = 0;
                    end else if (!stall) begin
                        m_bod[i]++;
                        for (int k = 0; k < 2; k++)
                            if (m_en[i][k]) m_act[i][k] = (m_act[i][k] + 1) & wmask[i];
                        e_step[i] = 1;
                        if (m_bod[i] == total(i)) m_ph[i] = 2;
                    end
                    2: begin
                        e_busy[i] = 0;
                        if (abort) begin
                            m_ph[i] = 0; m_zero[i] = 1;
                        end else begin
                            e_done[i] = 1; m_ph[i] = clrd[i] ? 3 : 0;
                        end
                    end
                    default: begin
                        m_act[i][0] = 0; m_act[i][1] = 0; m_zero[i] = 1; m_ph[i] = 0;
                    end
                endcase
            end
        end
    end

    bit chk_on = 1'b0;
    always @(negedge clk) begin
        if (chk_on) begin
            chk("a_busy", busy_a, e_busy[0]);
            chk("a_step", step_a, e_step[0]);
            chk("a_done", done_a, e_done[0]);
            chk("a_x", x_a, ex_x(0));
            chk("a_y", y_a, ex_y(0));
            chk("a_act0", act_a[7:0], m_act[0][0]);
            chk("a_act1", act_a[15:8], m_act[0][1]);
            chk("b_busy", busy_b, e_busy[1]);
            chk("b_step", step_b, e_step[1]);
            chk("b_done", done_b, e_done[1]);
            chk("b_x", x_b, ex_x(1));
            chk("b_y", y_b, ex_y(1));
            chk("b_act0", act_b[3:0], m_act[1][0]);
            chk("b_act1", act_b[7:4], m_act[1][1]);
        end
    end

    int r_steps, r_done_at, r_dact0, r_dact1;

    task automatic run(input int ol, input int il, input logic [1:0] en, input int stall_pct,
                       input int stall_from, input int abort_step, input bit noise);
        bit aborted;
        bit finished;
        int s;
        @(negedge clk);
        outer_last = 8'(ol); inner_last = 8'(il); act_en = en; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s = cyc; r_steps = 0; r_done_at = -1; r_dact0 = -1; r_dact1 = -1;
        aborted = 0; finished = 0;
        for (int c = 0; c < 3000; c++) begin
            if (step_a) r_steps++;
            if (done_a && r_done_at < 0) begin
                r_done_at = cyc - s; r_dact0 = act_a[7:0]; r_dact1 = act_a[15:8];
            end
            if (m_ph[0] == 0 && m_ph[1] == 0) begin
                finished = 1;
                break;
            end
            stall = ($urandom_range(99) < stall_pct) ||
                    (stall_from >= 0 && c >= stall_from && c < stall_from + 5);
            abort = (abort_step > 0 && !aborted && r_steps == abort_step);
            if (abort) aborted = 1;
            if (noise) begin
                start = (m_ph[0] == 1 && m_ph[1] == 1) && ($urandom_range(3) == 0);
                outer_last = 8'($urandom); inner_last = 8'($urandom); act_en = 2'($urandom);
            end
            @(negedge clk);
        end
        stall = 0; abort = 0; start = 0;
        if (!finished) chk("run_timeout", 0, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        #12;
        chk_on = 1'b1;
        chk("reset_busy", busy_a, 0);
        chk("reset_act", act_a, 0);
        #10 rst_n = 1'b1;

        run(9, 9, 2'b11, 0, -1, 0, 0);
        chk("l10x10_steps", r_steps, 100);
        chk("l10x10_done_cycle", r_done_at, 101);
        chk("l10x10_act0", r_dact0, 100);
        chk("l10x10_act1", r_dact1, 100);
        @(negedge clk);
        chk("l10x10_act_cleared", act_a, 0);
        chk("l10x10_b_act_held", act_b, 8'h44);

        run(0, 0, 2'b11, 0, -1, 0, 0);
        chk("single_steps", r_steps, 1);
        chk("single_done_cycle", r_done_at, 2);
        chk("single_act0", r_dact0, 1);

        run(2, 3, 2'b11, 0, 4, 0, 0);
        chk("stall_steps", r_steps, 12);
        chk("stall_done_cycle", r_done_at, 18);

        run(3, 3, 2'b11, 0, -1, 7, 0);
        chk("abort_steps", r_steps, 7);
        chk("abort_no_done", r_done_at, -1);
        chk("abort_act0", act_a[7:0], 7);
        chk("abort_x", x_a, 0);
        chk("abort_y", y_a, 0);

        run(4, 4, 2'b01, 0, -1, 0, 0);
        chk("w4_act0", act_b[3:0], 9);
        chk("w4_act1", act_b[7:4], 0);

        run(3, 2, 2'b10, 0, -1, 0, 1);
        chk("noise_steps", r_steps, 12);

        for (int r = 0; r < 25; r++) begin
            run($urandom_range(6), $urandom_range(6), 2'($urandom), $urandom_range(30), -1,
                ($urandom_range(3) == 0) ? $urandom_range(1, 6) : 0, 1);
        end

        @(negedge clk);
        outer_last = 8'd5; inner_last = 8'd5; act_en = 2'b11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_busy", busy_a, 0);
        chk("midreset_x", x_a, 0);
        chk("midreset_act", act_a, 0);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
